// File: rtl/axil_regfile_slave.sv
// -----------------------------------------------------------------------------
// axil_regfile_slave
//
// AXI4-Lite slave fronting a small register file for the AES accelerator
// control/status space. The host writes control registers over AXI; the core
// sees them on reg_out and supplies status words on reg_in, which the host
// reads back through the read-only slots selected by RO_MASK.
//
// Ports
//   clk, resetn        single clock, asynchronous active-low reset
//   s_axi_aw*          write address channel
//   s_axi_w*           write data channel (per-byte strobes)
//   s_axi_b*           write response channel (OKAY / SLVERR / DECERR)
//   s_axi_ar*          read address channel
//   s_axi_r*           read data channel (OKAY / DECERR)
//   reg_out            flat RW register contents, register i at
//                      [i*DATA_WIDTH +: DATA_WIDTH]; RO slots read as 0
//   reg_in             flat status inputs returned on reads of RO slots
//   wr_pulse           one-cycle strobe per register on a committed write
//   rd_pulse           one-cycle strobe per register on an accepted read
// -----------------------------------------------------------------------------
module axil_regfile_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           resetn,

    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,

    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,

    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,

    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Span is computed one bit wider so BASE_ADDR + span cannot wrap.
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(NUM_REGS * BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] rel;
        rel = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a >= BASE_ADDR) && (rel < SPAN);
    endfunction

    // Byte-offset bits fall away in the shift.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] rel;
        rel = (a - BASE_ADDR) >> OFS;
        return rel[IDX_W-1:0];
    endfunction

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wstate_t;

    wstate_t                              wstate;
    wstate_t                              wstate_nxt;
    logic                                 commit;
    logic                                 aw_held;
    logic                                 w_held;
    logic                                 aw_hs;
    logic                                 w_hs;
    logic [ADDR_WIDTH-1:0]                awaddr_q;
    logic [DATA_WIDTH-1:0]                wdata_q;
    logic [BYTES-1:0]                     wstrb_q;
    logic                                 w_hit;
    logic                                 w_ro;
    logic [IDX_W-1:0]                     w_idx;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;

    logic                                 ar_hs;
    logic                                 ar_hit;
    logic                                 ar_ro;
    logic [IDX_W-1:0]                     ar_idx;

    // Readies depend only on flops, never on the incoming valids.
    assign s_axi_bvalid  = (wstate == W_RESP);
    assign s_axi_awready = !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = !w_held  && !s_axi_bvalid;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid  && s_axi_wready;

    assign w_hit = addr_hit(awaddr_q);
    assign w_idx = addr_idx(awaddr_q);
    assign w_ro  = RO_MASK[w_idx];

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate <= W_COLLECT;
        end else begin
            wstate <= wstate_nxt;
        end
    end

    always_comb begin
        wstate_nxt = wstate;
        commit     = 1'b0;
        case (wstate)
            W_COLLECT: begin
                if (aw_held && w_held) begin
                    commit     = 1'b1;
                    wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wstate_nxt = W_COLLECT;
                end
            end
            default: wstate_nxt = W_COLLECT;
        endcase
    end

    // Capture flags, response code and write strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            s_axi_bresp <= RESP_OKAY;
            wr_pulse    <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                if (!w_hit) begin
                    s_axi_bresp <= RESP_DECERR;
                end else if (w_ro) begin
                    s_axi_bresp <= RESP_SLVERR;
                end else begin
                    s_axi_bresp     <= RESP_OKAY;
                    wr_pulse[w_idx] <= 1'b1;
                end
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
        end
    end

    // Holding registers carry payload only; the flags above qualify them.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            awaddr_q <= s_axi_awaddr;
        end
        if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
        end
    end

    // ---------------- register file ----------------
    // RO slots are never written, so their flops stay at 0 and trim away.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs <= '0;
        end else if (commit && w_hit && !w_ro) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb_q[b]) begin
                    regs[w_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end

    // ---------------- read path ----------------
    assign s_axi_arready = !s_axi_rvalid;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign ar_hit        = addr_hit(s_axi_araddr);
    assign ar_idx        = addr_idx(s_axi_araddr);
    assign ar_ro         = RO_MASK[ar_idx];

    // regs is sampled before this edge's commit lands, so a colliding read
    // returns the pre-write value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
            rd_pulse     <= '0;
        end else begin
            rd_pulse <= '0;
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                if (!ar_hit) begin
                    s_axi_rdata <= '0;
                    s_axi_rresp <= RESP_DECERR;
                end else begin
                    s_axi_rresp      <= RESP_OKAY;
                    rd_pulse[ar_idx] <= 1'b1;
                    if (ar_ro) begin
                        s_axi_rdata <= reg_in[int'(ar_idx)*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        s_axi_rdata <= regs[ar_idx];
                    end
                end
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_regfile_slave
//
// Two instances: a 32-bit/16-register slave with read-only slots 1 and 11,
// and a 64-bit/4-register slave with read-only slot 3. Directed sequences
// cover the basic paths, ordering, backpressure, collision and reset;
// a randomized phase is checked against an array-based register model.
// -----------------------------------------------------------------------------
module tb_axil_regfile_slave;

    localparam int          NR     = 16;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [15:0] RO     = 16'h0802;
    localparam int          B_NR   = 4;
    localparam logic [31:0] B_BASE = 32'h0000_1000;
    localparam logic [3:0]  B_RO   = 4'b1000;

    logic clk = 1'b0;
    logic resetn;
    logic resetn_b;
    always #5 clk = ~clk;

    // ---------------- instance A: 32-bit, 16 registers ----------------
    logic [31:0]      s_axi_awaddr;
    logic             s_axi_awvalid;
    logic             s_axi_awready;
    logic [31:0]      s_axi_wdata;
    logic [3:0]       s_axi_wstrb;
    logic             s_axi_wvalid;
    logic             s_axi_wready;
    logic [1:0]       s_axi_bresp;
    logic             s_axi_bvalid;
    logic             s_axi_bready;
    logic [31:0]      s_axi_araddr;
    logic             s_axi_arvalid;
    logic             s_axi_arready;
    logic [31:0]      s_axi_rdata;
    logic [1:0]       s_axi_rresp;
    logic             s_axi_rvalid;
    logic             s_axi_rready;
    logic [NR*32-1:0] reg_out;
    logic [NR*32-1:0] reg_in;
    logic [NR-1:0]    wr_pulse;
    logic [NR-1:0]    rd_pulse;

    axil_regfile_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (NR),
        .BASE_ADDR  (BASE),
        .RO_MASK    (RO)
    ) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .reg_out       (reg_out),
        .reg_in        (reg_in),
        .wr_pulse      (wr_pulse),
        .rd_pulse      (rd_pulse)
    );

    // ---------------- instance B: 64-bit, 4 registers ----------------
    logic [31:0]        b_awaddr;
    logic               b_awvalid;
    logic               b_awready;
    logic [63:0]        b_wdata;
    logic [7:0]         b_wstrb;
    logic               b_wvalid;
    logic               b_wready;
    logic [1:0]         b_bresp;
    logic               b_bvalid;
    logic               b_bready;
    logic [31:0]        b_araddr;
    logic               b_arvalid;
    logic               b_arready;
    logic [63:0]        b_rdata;
    logic [1:0]         b_rresp;
    logic               b_rvalid;
    logic               b_rready;
    logic [B_NR*64-1:0] b_reg_out;
    logic [B_NR*64-1:0] b_reg_in;
    logic [B_NR-1:0]    b_wr_pulse;
    logic [B_NR-1:0]    b_rd_pulse;

    axil_regfile_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .NUM_REGS   (B_NR),
        .BASE_ADDR  (B_BASE),
        .RO_MASK    (B_RO)
    ) u_dut_b (
        .clk           (clk),
        .resetn        (resetn_b),
        .s_axi_awaddr  (b_awaddr),
        .s_axi_awvalid (b_awvalid),
        .s_axi_awready (b_awready),
        .s_axi_wdata   (b_wdata),
        .s_axi_wstrb   (b_wstrb),
        .s_axi_wvalid  (b_wvalid),
        .s_axi_wready  (b_wready),
        .s_axi_bresp   (b_bresp),
        .s_axi_bvalid  (b_bvalid),
        .s_axi_bready  (b_bready),
        .s_axi_araddr  (b_araddr),
        .s_axi_arvalid (b_arvalid),
        .s_axi_arready (b_arready),
        .s_axi_rdata   (b_rdata),
        .s_axi_rresp   (b_rresp),
        .s_axi_rvalid  (b_rvalid),
        .s_axi_rready  (b_rready),
        .reg_out       (b_reg_out),
        .reg_in        (b_reg_in),
        .wr_pulse      (b_wr_pulse),
        .rd_pulse      (b_rd_pulse)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Register model for instance A.
    logic [31:0] mdl [NR];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] m;
        for (int k = 0; k < 8; k++) m[k*8 +: 8] = {8{s[k]}};
        return (old & ~m) | (d & m);
    endfunction

    // Full write on A: both channels offered together, waits for both
    // handshakes, then checks the response arrives one edge later.
    task automatic a_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [15:0] pulse);
        bit aw_done, w_done, a_hs, w_hs;
        int cyc;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        s_axi_wdata  = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            a_hs = s_axi_awvalid && s_axi_awready;
            w_hs = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1;
            if (a_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_hs) begin w_done = 1; s_axi_wvalid = 1'b0; end
            cyc++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("wr_accept", 64'(aw_done && w_done), 64'(1));
        @(posedge clk); #1;
        chk("wr_bvalid", 64'(s_axi_bvalid), 64'(1));
        resp = s_axi_bresp; pulse = wr_pulse;
        @(posedge clk); #1;
        chk("wr_bvalid_clr", 64'(s_axi_bvalid), 64'(0));
        chk("wr_pulse_1cyc", 64'(wr_pulse), 64'(0));
    endtask

    task automatic a_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic [15:0] pulse);
        bit hs, done;
        int cyc;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        done = 0; cyc = 0;
        while (!done && cyc < 20) begin
            hs = s_axi_arvalid && s_axi_arready;
            @(posedge clk); #1;
            if (hs) done = 1;
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        chk("rd_accept", 64'(done), 64'(1));
        chk("rd_rvalid", 64'(s_axi_rvalid), 64'(1));
        d = s_axi_rdata; resp = s_axi_rresp; pulse = rd_pulse;
        @(posedge clk); #1;
        chk("rd_rvalid_clr", 64'(s_axi_rvalid), 64'(0));
        chk("rd_pulse_1cyc", 64'(rd_pulse), 64'(0));
    endtask

    task automatic b_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [1:0] resp, output logic [3:0] pulse);
        bit aw_done, w_done, a_hs, w_hs;
        int cyc;
        b_awaddr = a; b_awvalid = 1'b1;
        b_wdata = d; b_wstrb = s; b_wvalid = 1'b1; b_bready = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            a_hs = b_awvalid && b_awready;
            w_hs = b_wvalid && b_wready;
            @(posedge clk); #1;
            if (a_hs) begin aw_done = 1; b_awvalid = 1'b0; end
            if (w_hs) begin w_done = 1; b_wvalid = 1'b0; end
            cyc++;
        end
        b_awvalid = 1'b0; b_wvalid = 1'b0;
        chk("b_wr_accept", 64'(aw_done && w_done), 64'(1));
        @(posedge clk); #1;
        chk("b_wr_bvalid", 64'(b_bvalid), 64'(1));
        resp = b_bresp; pulse = b_wr_pulse;
        @(posedge clk); #1;
        chk("b_wr_bvalid_clr", 64'(b_bvalid), 64'(0));
    endtask

    task automatic b_read(input logic [31:0] a, output logic [63:0] d,
                          output logic [1:0] resp, output logic [3:0] pulse);
        bit hs, done;
        int cyc;
        b_araddr = a; b_arvalid = 1'b1; b_rready = 1'b1;
        done = 0; cyc = 0;
        while (!done && cyc < 20) begin
            hs = b_arvalid && b_arready;
            @(posedge clk); #1;
            if (hs) done = 1;
            cyc++;
        end
        b_arvalid = 1'b0;
        chk("b_rd_rvalid", 64'(b_rvalid && done), 64'(1));
        d = b_rdata; resp = b_rresp; pulse = b_rd_pulse;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [1:0]  exp_resp;
        logic [15:0] pulse;
        logic [15:0] exp_pulse;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic [31:0] addr;
        logic [31:0] d;
        logic [31:0] old4;
        logic [31:0] stat;
        logic [3:0]  s;
        logic [63:0] t;
        logic [63:0] brd;
        logic [3:0]  bpulse;
        int          idx;
        int          lo;
        bit          in_rng;

        resetn = 1'b0; resetn_b = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        b_awaddr = '0; b_awvalid = 1'b0; b_wdata = '0; b_wstrb = '0; b_wvalid = 1'b0;
        b_bready = 1'b1; b_araddr = '0; b_arvalid = 1'b0; b_rready = 1'b1;
        for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = $urandom();
        reg_in[1*32 +: 32] = 32'h0000_CAFE;
        for (int i = 0; i < B_NR; i++) b_reg_in[i*64 +: 64] = {$urandom(), $urandom()};
        for (int i = 0; i < NR; i++) mdl[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 64'(s_axi_awready), 64'(1));
        chk("rst_wready",  64'(s_axi_wready),  64'(1));
        chk("rst_arready", 64'(s_axi_arready), 64'(1));
        chk("rst_bvalid",  64'(s_axi_bvalid),  64'(0));
        chk("rst_rvalid",  64'(s_axi_rvalid),  64'(0));
        chk("rst_resps",   64'({s_axi_bresp, s_axi_rresp}), 64'(0));
        chk("rst_rdata",   64'(s_axi_rdata), 64'(0));
        chk("rst_regs",    64'(reg_out != '0), 64'(0));
        chk("rst_pulses",  64'({wr_pulse, rd_pulse}), 64'(0));
        resetn = 1'b1; resetn_b = 1'b1;
        @(posedge clk); #1;

        // Basic write / read of register 2.
        a_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, resp, pulse);
        mdl[2] = 32'hDEAD_BEEF;
        chk("basic_bresp", 64'(resp), 64'(0));
        chk("basic_wr_pulse", 64'(pulse), 64'(16'h0004));
        chk("basic_reg_out", 64'(reg_out[2*32 +: 32]), 64'(32'hDEAD_BEEF));
        a_read(BASE + 32'h8, rd, resp, pulse);
        chk("basic_rdata", 64'(rd), 64'(32'hDEAD_BEEF));
        chk("basic_rresp", 64'(resp), 64'(0));
        chk("basic_rd_pulse", 64'(pulse), 64'(16'h0004));

        // Byte strobes on register 3.
        a_write(BASE + 32'hC, 32'h1122_3344, 4'hF, resp, pulse);
        a_write(BASE + 32'hC, 32'hAABB_CCDD, 4'h5, resp, pulse);
        mdl[3] = 32'h11BB_33DD;
        a_read(BASE + 32'hC, rd, resp, pulse);
        chk("strb_rdata", 64'(rd), 64'(32'h11BB_33DD));

        // Zero strobe: data untouched, pulse and OKAY still produced.
        a_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'h0, resp, pulse);
        chk("strb0_bresp", 64'(resp), 64'(0));
        chk("strb0_pulse", 64'(pulse), 64'(16'h0008));
        chk("strb0_reg", 64'(reg_out[3*32 +: 32]), 64'(32'h11BB_33DD));

        // Access errors.
        a_write(BASE + 32'h4, 32'h1234_5678, 4'hF, resp, pulse);
        chk("ro_bresp", 64'(resp), 64'(2'b10));
        chk("ro_wr_pulse", 64'(pulse), 64'(0));
        chk("ro_reg_out", 64'(reg_out[1*32 +: 32]), 64'(0));
        a_read(BASE + 32'h4, rd, resp, pulse);
        chk("ro_rdata", 64'(rd), 64'(32'h0000_CAFE));
        chk("ro_rresp", 64'(resp), 64'(0));
        chk("ro_rd_pulse", 64'(pulse), 64'(16'h0002));
        a_read(BASE + NR*4, rd, resp, pulse);
        chk("oor_rdata", 64'(rd), 64'(0));
        chk("oor_rresp", 64'(resp), 64'(2'b11));
        chk("oor_rd_pulse", 64'(pulse), 64'(0));
        a_write(BASE + NR*4, 32'h1, 4'hF, resp, pulse);
        chk("oor_bresp", 64'(resp), 64'(2'b11));
        chk("oor_wr_pulse", 64'(pulse), 64'(0));

        // W three cycles ahead of AW, then response backpressure.
        s_axi_wdata = 32'h5555_AAAA; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b0;
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        chk("ord_wready_low", 64'(s_axi_wready), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("ord_no_early", 64'({s_axi_bvalid, wr_pulse}), 64'(0));
        s_axi_awaddr = BASE + 32'h14; s_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        chk("ord_no_commit_yet", 64'({s_axi_bvalid, wr_pulse}), 64'(0));
        @(posedge clk); #1;
        mdl[5] = 32'h5555_AAAA;
        chk("ord_bvalid", 64'(s_axi_bvalid), 64'(1));
        chk("ord_wr_pulse", 64'(wr_pulse), 64'(16'h0020));
        chk("ord_reg", 64'(reg_out[5*32 +: 32]), 64'(32'h5555_AAAA));
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_bvalid", 64'(s_axi_bvalid), 64'(1));
            chk("bp_bresp", 64'(s_axi_bresp), 64'(0));
            chk("bp_readies", 64'({s_axi_awready, s_axi_wready}), 64'(0));
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 64'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 64'(3'b011));

        // Read backpressure with a changing status input.
        stat = 32'h0BAD_F00D;
        reg_in[11*32 +: 32] = stat;
        s_axi_araddr = BASE + 32'd44; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        reg_in[11*32 +: 32] = 32'h7777_7777;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rbp_rdata", 64'(s_axi_rdata), 64'(stat));
            chk("rbp_rvalid", 64'({s_axi_rvalid, s_axi_arready}), 64'(2'b10));
        end
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        chk("rbp_release", 64'(s_axi_rvalid), 64'(0));
        a_read(BASE + 32'd44, rd, resp, pulse);
        chk("rbp_new_status", 64'(rd), 64'(32'h7777_7777));

        // Read of register 4 accepted on the commit edge of a write to it.
        old4 = 32'h4444_4444;
        a_write(BASE + 32'h10, old4, 4'hF, resp, pulse);
        s_axi_awaddr = BASE + 32'h10; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h9999_0000; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = BASE + 32'h10; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        mdl[4] = 32'h9999_0000;
        chk("coll_rvalid", 64'(s_axi_rvalid), 64'(1));
        chk("coll_rdata_old", 64'(s_axi_rdata), 64'(old4));
        chk("coll_wr_pulse", 64'(wr_pulse), 64'(16'h0010));
        chk("coll_reg_new", 64'(reg_out[4*32 +: 32]), 64'(32'h9999_0000));
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        chk("coll_done", 64'({s_axi_rvalid, s_axi_bvalid}), 64'(0));

        // Randomized traffic against the model.
        for (int n = 0; n < 160; n++) begin
            idx  = int'($urandom_range(0, 18));
            lo   = int'($urandom_range(0, 3));
            addr = (idx == 18) ? (BASE - 32'd4 + 32'(lo)) : (BASE + 32'(idx*4 + lo));
            in_rng = (idx < NR);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = $urandom();
            end
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom();
                s = 4'($urandom_range(0, 15));
                a_write(addr, d, s, resp, pulse);
                exp_resp = 2'b11; exp_pulse = '0;
                if (in_rng) begin
                    if (RO[idx]) begin
                        exp_resp = 2'b10;
                    end else begin
                        exp_resp = 2'b00;
                        exp_pulse = 16'(1) << idx;
                        t = merge(64'(mdl[idx]), 64'(d), 8'(s));
                        mdl[idx] = t[31:0];
                    end
                end
                chk("rnd_bresp", 64'(resp), 64'(exp_resp));
                chk("rnd_wr_pulse", 64'(pulse), 64'(exp_pulse));
            end else begin
                a_read(addr, rd, resp, pulse);
                exp_rd = '0; exp_resp = 2'b11; exp_pulse = '0;
                if (in_rng) begin
                    exp_resp = 2'b00;
                    exp_pulse = 16'(1) << idx;
                    exp_rd = RO[idx] ? reg_in[idx*32 +: 32] : mdl[idx];
                end
                chk("rnd_rdata", 64'(rd), 64'(exp_rd));
                chk("rnd_rresp", 64'(resp), 64'(exp_resp));
                chk("rnd_rd_pulse", 64'(pulse), 64'(exp_pulse));
            end
        end
        for (int i = 0; i < NR; i++) begin
            chk("sweep_reg_out", 64'(reg_out[i*32 +: 32]), 64'(RO[i] ? 32'h0 : mdl[i]));
        end

        // Reset between the AW and W handshakes on instance A.
        a_write(BASE + 32'h18, 32'hA5A5_A5A5, 4'hF, resp, pulse);
        s_axi_awaddr = BASE + 32'h18; s_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        chk("arst_aw_held", 64'(s_axi_awready), 64'(0));
        #2 resetn = 1'b0;
        #1;
        chk("arst_regs", 64'(reg_out != '0), 64'(0));
        chk("arst_valids", 64'({s_axi_bvalid, s_axi_rvalid}), 64'(0));
        chk("arst_readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(3'b111));
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        s_axi_wdata = 32'h1357_9BDF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_no_stale", 64'({s_axi_bvalid, wr_pulse}), 64'(0));
        s_axi_awaddr = BASE + 32'h18; s_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        @(posedge clk); #1;
        chk("arst_post_bvalid", 64'({s_axi_bvalid, s_axi_bresp}), 64'(3'b100));
        @(posedge clk); #1;
        a_read(BASE + 32'h18, rd, resp, pulse);
        chk("arst_post_rdata", 64'(rd), 64'(32'h1357_9BDF));

        // Instance B: 64-bit data, 4 registers.
        b_write(B_BASE + 32'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, resp, bpulse);
        chk("b_bresp", 64'(resp), 64'(0));
        chk("b_wr_pulse", 64'(bpulse), 64'(4'b0100));
        chk("b_reg2", b_reg_out[2*64 +: 64], 64'h0123_4567_89AB_CDEF);
        b_awaddr = B_BASE + 32'h8; b_awvalid = 1'b1;
        @(posedge clk); #1;
        b_awvalid = 1'b0;
        #2 resetn_b = 1'b0;
        #1;
        chk("b_rst_regs", 64'(b_reg_out != '0), 64'(0));
        chk("b_rst_valids", 64'({b_bvalid, b_rvalid}), 64'(0));
        chk("b_rst_readies", 64'({b_awready, b_wready, b_arready}), 64'(3'b111));
        @(posedge clk); #1;
        resetn_b = 1'b1;
        b_write(B_BASE + 32'h8, 64'hFEDC_BA98_7654_3210, 8'h0F, resp, bpulse);
        chk("b_post_bresp", 64'(resp), 64'(0));
        chk("b_post_pulse", 64'(bpulse), 64'(4'b0010));
        b_read(B_BASE + 32'h8, brd, resp, bpulse);
        chk("b_post_rdata", brd, 64'h0000_0000_7654_3210);
        chk("b_post_rd_pulse", 64'(bpulse), 64'(4'b0010));
        b_read(B_BASE + 32'h10, brd, resp, bpulse);
        chk("b_reg2_cleared", brd, 64'h0);
        b_read(B_BASE + 32'h18, brd, resp, bpulse);
        chk("b_ro_rdata", brd, b_reg_in[3*64 +: 64]);
        chk("b_ro_rresp", 64'(resp), 64'(0));
        b_write(B_BASE + 32'h18, 64'h1, 8'hFF, resp, bpulse);
        chk("b_ro_bresp", 64'(resp), 64'(2'b10));
        chk("b_ro_wr_pulse", 64'(bpulse), 64'(0));
        b_read(B_BASE + 32'h20, brd, resp, bpulse);
        chk("b_oor", 64'({brd != 64'h0, resp, bpulse}), 64'({1'b0, 2'b11, 4'b0000}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
